// File: rtl/tinymcu_bus_pkg.sv
// Shared types for the memory/MMIO bus arbiter: FSM states and master ids.
package tinymcu_bus_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} bus_state_t;

   typedef logic master_id_t;

   localparam master_id_t M0 = 1'b0;
   localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter. It picks the winner combinationally from the live requests.
// It remembers which master was granted last, so a tie can go to the other master.
module rr_arbiter2
   import tinymcu_bus_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       fair,
   input  logic       grant_en,
   output master_id_t gnt_id,
   output logic       gnt_valid
);

   // Master granted most recently. It resets to M1 so that the first tie goes to M0.
   master_id_t r_last;

   // Select the winner. With fair set, a tie goes to the master not granted last.
   // With fair clear, M0 always wins a tie.
   always_comb begin
      gnt_valid = |req;
      gnt_id    = M0;
      if (req == 2'b11) begin
         gnt_id = (fair && (r_last == M0)) ? M1 : M0;
      end else if (req == 2'b10) begin
         gnt_id = M1;
      end
   end

   // Move the pointer on every accepted grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= M1;
      end else if (grant_en && gnt_valid) begin
         r_last <= gnt_id;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Lets two masters share one memory/MMIO bus.
// The arbiter grants one transaction at a time and drives the bus strobes for it.
// It waits RD_LAT cycles for read data, then returns a one-cycle ack to the owner.
// Handshake: a master holds req and its we/addr/wdata stable until it sees its ack pulse.
// A req that is still high in the cycle after the ack starts a new transaction.
module mem_bus_arbiter
   import tinymcu_bus_pkg::*;
#(
   parameter int AW     = 16,
   parameter int DW     = 8,
   parameter int RD_LAT = 1,
   parameter int FAIR   = 1
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] bus_addr,
   output logic          bus_we,
   output logic          bus_oe,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   output logic          bus_owner
);

   localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);
   localparam logic       L_FAIR   = (FAIR != 0);

   bus_state_t    r_state;
   master_id_t    r_owner;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [3:0]    r_cnt;
   logic          r_bus_we;
   logic          r_bus_oe;
   logic          r_m0_ack;
   logic          r_m1_ack;
   logic [DW-1:0] r_rdata;

   logic [1:0]    w_req;
   logic          w_grant_en;
   master_id_t    w_gnt_id;
   logic          w_gnt_valid;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;

   assign w_req      = {m1_req, m0_req};
   assign w_grant_en = (r_state == IDLE);

   rr_arbiter2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (w_req),
      .fair      (L_FAIR),
      .grant_en  (w_grant_en),
      .gnt_id    (w_gnt_id),
      .gnt_valid (w_gnt_valid)
   );

   // Route the winning master's command to the latch registers.
   always_comb begin
      w_sel_we    = m0_we;
      w_sel_addr  = m0_addr;
      w_sel_wdata = m0_wdata;
      if (w_gnt_id == M1) begin
         w_sel_we    = m1_we;
         w_sel_addr  = m1_addr;
         w_sel_wdata = m1_wdata;
      end
   end

   // Transaction FSM. It runs IDLE -> ISSUE -> [WAIT] -> ACK -> IDLE and registers every output.
   // Address and write data keep their last values while idle; only the strobes drop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_owner  <= M0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_cnt    <= '0;
         r_bus_we <= 1'b0;
         r_bus_oe <= 1'b0;
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
         r_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_valid) begin
                  r_owner  <= w_gnt_id;
                  r_we     <= w_sel_we;
                  r_addr   <= w_sel_addr;
                  r_wdata  <= w_sel_wdata;
                  r_bus_we <= w_sel_we;
                  r_bus_oe <= ~w_sel_we;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_we) begin
                  r_bus_we <= 1'b0;
                  r_m0_ack <= (r_owner == M0);
                  r_m1_ack <= (r_owner == M1);
                  r_state  <= ACK;
               end else begin
                  r_cnt   <= CNT_INIT;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_rdata  <= bus_rdata;
                  r_bus_oe <= 1'b0;
                  r_m0_ack <= (r_owner == M0);
                  r_m1_ack <= (r_owner == M1);
                  r_state  <= ACK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ACK: begin
               r_m0_ack <= 1'b0;
               r_m1_ack <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign m0_ack    = r_m0_ack;
   assign m1_ack    = r_m1_ack;
   assign rdata     = r_rdata;
   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign bus_we    = r_bus_we;
   assign bus_oe    = r_bus_oe;
   assign bus_owner = r_owner;

endmodule
